// File: rtl/audio_pkg.sv
// Shared audio sample definitions for the filter and the downstream sample register.
package audio_pkg;
  localparam int unsigned DATA_W = 24;
  typedef logic signed [DATA_W-1:0] sample_t;
endpackage

// File: rtl/sample_ring.sv
// Write-pointer ring buffer: old_data shows the entry about to be overwritten, so the
// caller reads the oldest sample and writes the newest on the same edge.
module sample_ring #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned LOG2_N = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] old_data
);
  localparam int unsigned Depth = 2 ** LOG2_N;

  logic [DATA_W-1:0] r_mem [Depth];
  logic [LOG2_N-1:0] r_wptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr <= '0;
    end else if (wr_en) begin
      r_mem[r_wptr] <= wr_data;
      r_wptr        <= r_wptr + 1'b1;  // power-of-two depth wraps naturally
    end
  end

  assign old_data = r_mem[r_wptr];
endmodule

// File: rtl/avg_filter_24.sv
// N-tap moving-average filter for signed audio samples with a running sum,
// one-cycle registered output and an optional unfiltered bypass.
module avg_filter_24 #(
  parameter int unsigned DATA_W = audio_pkg::DATA_W,
  parameter int unsigned LOG2_N = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     bypass,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     primed
);
  import audio_pkg::*;

  localparam int unsigned SUM_W = DATA_W + LOG2_N;
  localparam logic [LOG2_N-1:0] COUNT_LAST = '1;

  logic [DATA_W-1:0]        w_old_data;
  logic signed [SUM_W-1:0]  w_in_ext;
  logic signed [SUM_W-1:0]  w_old_ext;
  logic signed [SUM_W-1:0]  w_new_sum;
  logic signed [DATA_W-1:0] w_mean;

  logic signed [SUM_W-1:0]  r_sum;
  logic [LOG2_N-1:0]        r_count;
  logic                     r_primed;
  logic                     r_out_valid;
  logic signed [DATA_W-1:0] r_out_data;

  sample_ring #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_ring (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (in_valid),
    .wr_data  (in_data),
    .old_data (w_old_data)
  );

  assign w_in_ext  = {{LOG2_N{in_data[DATA_W-1]}}, in_data};
  assign w_old_ext = {{LOG2_N{w_old_data[DATA_W-1]}}, w_old_data};
  assign w_new_sum = r_sum + w_in_ext - w_old_ext;
  // Dropping the low bits of a two's-complement sum is a floor divide by N.
  assign w_mean    = w_new_sum[SUM_W-1:LOG2_N];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum       <= '0;
      r_count     <= '0;
      r_primed    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum      <= w_new_sum;
        r_out_data <= bypass ? in_data : w_mean;
        if (!r_primed) begin
          if (r_count == COUNT_LAST) begin
            r_primed <= 1'b1;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign primed    = r_primed;
endmodule

// File: tb/tb_avg_filter_24.sv
// Bench for avg_filter_24: directed scenarios with literal expectations plus random
// traffic, all checked every cycle against a queue-based moving-average model.
module tb_avg_filter_24;
  import audio_pkg::*;

  logic    clk = 1'b0;
  logic    reset = 1'b1;
  logic    in_valid = 1'b0;
  sample_t in_data = '0;
  logic    bypass = 1'b0;
  logic    out_valid;
  sample_t out_data;
  logic    primed;

  int total = 0;
  int bad = 0;

  avg_filter_24 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .bypass    (bypass),
    .out_valid (out_valid),
    .out_data  (out_data),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  // Reference model: last 8 accepted samples, mean is the floored sum / 8.
  longint hist[$];
  int     acc_cnt = 0;
  bit     model_on = 1'b0;
  bit     exp_valid = 1'b0;
  longint exp_data = 0;
  bit     exp_primed = 1'b0;

  function automatic longint floor_div8(input longint s);
    longint q;
    q = s / 8;
    if ((s % 8 != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  always begin
    longint s;
    @(posedge clk);
    if (reset) begin
      hist.delete();
      acc_cnt    = 0;
      exp_valid  = 1'b0;
      exp_data   = 0;
      exp_primed = 1'b0;
      model_on   = 1'b1;
    end else if (in_valid) begin
      hist.push_back(longint'(in_data));
      if (hist.size() > 8) void'(hist.pop_front());
      s = 0;
      foreach (hist[i]) s += hist[i];
      acc_cnt++;
      exp_valid  = 1'b1;
      exp_data   = bypass ? longint'(in_data) : floor_div8(s);
      exp_primed = (acc_cnt >= 8);
    end else begin
      exp_valid = 1'b0;
    end
    #1;
    if (model_on) begin
      total++;
      if (out_valid !== exp_valid || primed !== exp_primed ||
          longint'(out_data) != exp_data || $isunknown(out_data)) begin
        bad++;
        $display("FAIL model t=%0t: got valid=%b data=%0d primed=%b, want valid=%b data=%0d primed=%b",
                 $time, out_valid, out_data, primed, exp_valid, exp_data, exp_primed);
      end
    end
  end

  task automatic pin(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic send(input sample_t v, input logic bp);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    bypass   = bp;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = sample_t'($urandom);
      bypass   = $urandom_range(0, 1) != 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    pin("reset out_valid", longint'(out_valid), 0);
    pin("reset out_data", longint'(out_data), 0);
    pin("reset primed", longint'(primed), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    sample_t v;
    repeat (2) @(posedge clk);
    do_reset();

    // Ramp-up with 800s, then step down to -400.
    for (int i = 1; i <= 8; i++) begin
      send(24'sd800, 1'b0);
      pin("ramp800 data", longint'(out_data), 100 * i);
      pin("ramp800 primed", longint'(primed), (i == 8) ? 1 : 0);
    end
    for (int i = 1; i <= 8; i++) begin
      send(-24'sd400, 1'b0);
      pin("step-400 data", longint'(out_data), 800 - 150 * i);
    end
    idle(1);

    // Floor rounding of a lone negative sample.
    do_reset();
    send(-24'sd1, 1'b0);
    pin("minus1 data", longint'(out_data), -1);
    idle(2);

    // Full-scale positive then negative, back to back.
    do_reset();
    repeat (16) send(24'sh7FFFFF, 1'b0);
    pin("fullpos data", longint'(out_data), 8388607);
    repeat (8) send(24'sh800000, 1'b0);
    pin("fullneg data", longint'(out_data), -8388608);
    idle(1);

    // Bypass then average resumes immediately.
    do_reset();
    send(24'sd10, 1'b1);
    pin("bypass 10", longint'(out_data), 10);
    send(24'sd20, 1'b1);
    pin("bypass 20", longint'(out_data), 20);
    send(24'sd30, 1'b1);
    pin("bypass 30", longint'(out_data), 30);
    send(24'sd40, 1'b0);
    pin("unbypass 40", longint'(out_data), 12);
    idle(1);

    // Mid-stream reset, then a gapped sample.
    for (int i = 0; i < 5; i++) send(24'sd1000, 1'b0);
    do_reset();
    idle(3);
    send(24'sd80, 1'b0);
    pin("post-reset 80", longint'(out_data), 10);
    pin("post-reset primed", longint'(primed), 0);
    idle(4);
    pin("hold out_valid", longint'(out_valid), 0);
    pin("hold out_data", longint'(out_data), 10);

    // Random traffic with occasional bypass and resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset    = ($urandom_range(0, 299) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       v = 24'sh7FFFFF;
        1:       v = 24'sh800000;
        2:       v = sample_t'($urandom_range(0, 15)) - 24'sd8;
        default: v = sample_t'($urandom);
      endcase
      in_data = v;
      bypass  = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
